// File: rtl/edabk_wb_pkg.sv
// Shared types for the Wishbone classic initiator:
// command record, FSM states and default bus widths.
package edabk_wb_pkg;

    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = WB_DATA_W / 8;
    localparam int WB_TMO_W  = 16;

    typedef struct packed {
        logic                 we;
        logic [WB_ADDR_W-1:0] adr;
        logic [WB_DATA_W-1:0] dat;
        logic [WB_SEL_W-1:0]  sel;
    } wb_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RESP
    } wb_init_state_e;

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous command FIFO of wb_cmd_t records.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_cmd_fifo
    import edabk_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  wb_cmd_t din,
    input  logic    pop,
    output wb_cmd_t dout,
    output logic    full,
    output logic    empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    wb_cmd_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_en, rd_en;

    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (wr_en && !rd_en) cnt_d = cnt_q + CNT_W'(1);
        else if (rd_en && !wr_en) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/wb_initiator.sv
// Wishbone classic initiator: one bus cycle per queued command, one response each.
// Define WB_INIT_TIMEOUT_EN to abort bus cycles that see no ack within TIMEOUT_CYCLES.
module wb_initiator
    import edabk_wb_pkg::*;
#(
    parameter int ADDR_W         = WB_ADDR_W,
    parameter int DATA_W         = WB_DATA_W,
    parameter int FIFO_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [ADDR_W-1:0]   cmd_adr,
    input  logic [DATA_W-1:0]   cmd_dat,
    input  logic [DATA_W/8-1:0] cmd_sel,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_dat,
    output logic                rsp_err,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [ADDR_W-1:0]   wbm_adr_o,
    output logic [DATA_W-1:0]   wbm_dat_o,
    output logic [DATA_W/8-1:0] wbm_sel_o,
    input  logic [DATA_W-1:0]   wbm_dat_i,
    input  logic                wbm_ack_i,
    output logic                busy
);

    localparam int SEL_W = DATA_W / 8;

    if (FIFO_DEPTH < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("wb_initiator: FIFO_DEPTH must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    wb_init_state_e    state_q, state_d;
    wb_cmd_t           push_cmd, head;
    logic              fifo_full, fifo_empty, push, pop, tmo_hit;
    logic              cyc_q, cyc_d, we_q, we_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_dat_q, rsp_dat_d;

    assign push_cmd = '{
        we:  cmd_we,
        adr: WB_ADDR_W'(cmd_adr),
        dat: WB_DATA_W'(cmd_dat),
        sel: WB_SEL_W'(cmd_sel)
    };

    assign push = cmd_valid && cmd_ready;
    assign pop  = !fifo_empty &&
                  ((state_q == ST_IDLE) || (state_q == ST_RESP && rsp_ready));

    wb_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_cmd),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef WB_INIT_TIMEOUT_EN
    logic [WB_TMO_W-1:0] tmo_q, tmo_d;
    logic                rsp_err_q, rsp_err_d;

    assign tmo_hit = (tmo_q == WB_TMO_W'(TIMEOUT_CYCLES - 1));
    assign rsp_err = rsp_err_q;

    always_comb begin
        tmo_d     = tmo_q;
        rsp_err_d = rsp_err_q;
        if (pop) tmo_d = '0;
        else if (state_q == ST_BUS) tmo_d = tmo_q + WB_TMO_W'(1);
        // An ack arriving on the expiry cycle still completes normally.
        if (state_q == ST_BUS) begin
            if (wbm_ack_i) rsp_err_d = 1'b0;
            else if (tmo_hit) rsp_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            rsp_err_q <= rsp_err_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (!fifo_empty) state_d = ST_BUS;
            ST_BUS:  if (wbm_ack_i || tmo_hit) state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = fifo_empty ? ST_IDLE : ST_BUS;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        if (state_q == ST_RESP && rsp_ready) rsp_valid_d = 1'b0;
        if (state_q == ST_BUS) begin
            if (wbm_ack_i) begin
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_dat_d   = we_q ? '0 : wbm_dat_i;
            end else if (tmo_hit) begin
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_dat_d   = '0;
            end
        end
        if (pop) begin
            cyc_d = 1'b1;
            we_d  = head.we;
            adr_d = ADDR_W'(head.adr);
            dat_d = DATA_W'(head.dat);
            sel_d = SEL_W'(head.sel);
        end
    end

    assign cmd_ready = !fifo_full;
    assign busy      = !fifo_empty || (state_q != ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = sel_q;

endmodule
